// File: rtl/evt_pkt_mux_if.sv
// Bus bundle for evt_pkt_mux: pass-through stream, merged output stream,
// payload channel writes and the header-generator side channel.
interface evt_pkt_mux_if #(
   parameter int DATA_WIDTH     = 64,
   parameter int CTRL_WIDTH     = 8,
   parameter int WORD_WIDTH     = 64,
   parameter int NUM_CHAN       = 4,
   parameter int PLD_DEPTH_BITS = 6
);
   logic [DATA_WIDTH-1:0]          in_data;
   logic [CTRL_WIDTH-1:0]          in_ctrl;
   logic                           in_wr;
   logic                           in_rdy;
   logic [DATA_WIDTH-1:0]          out_data;
   logic [CTRL_WIDTH-1:0]          out_ctrl;
   logic                           out_wr;
   logic                           out_rdy;
   logic [NUM_CHAN*WORD_WIDTH-1:0] pld_din;
   logic [NUM_CHAN-1:0]            pld_wr;
   logic [NUM_CHAN-1:0]            pld_full;
   logic [3:0]                     hdr_word_num;
   logic [DATA_WIDTH-1:0]          hdr_data;
   logic [CTRL_WIDTH-1:0]          hdr_ctrl;
   logic [2:0]                     evt_chan;
   logic [PLD_DEPTH_BITS:0]        evt_len;
   logic                           evt_pkt_sent;
   logic [31:0]                    evt_pkt_count;

   modport slave (
      input  in_data, in_ctrl, in_wr, out_rdy, pld_din, pld_wr, hdr_data, hdr_ctrl,
      output in_rdy, out_data, out_ctrl, out_wr, pld_full, hdr_word_num,
             evt_chan, evt_len, evt_pkt_sent, evt_pkt_count
   );

   modport master (
      output in_data, in_ctrl, in_wr, out_rdy, pld_din, pld_wr, hdr_data, hdr_ctrl,
      input  in_rdy, out_data, out_ctrl, out_wr, pld_full, hdr_word_num,
             evt_chan, evt_len, evt_pkt_sent, evt_pkt_count
   );
endinterface

// File: rtl/evt_pkt_mux.sv
// Merges a pass-through packet stream with event packets built from an external
// header plus payload words drained round-robin from NUM_CHAN payload buffers.
module evt_pkt_mux #(
   parameter int DATA_WIDTH        = 64,
   parameter int CTRL_WIDTH        = 8,
   parameter int WORD_WIDTH        = 64,
   parameter int NUM_CHAN          = 4,
   parameter int PLD_DEPTH_BITS    = 6,
   parameter int NUM_WORDS_PAYLOAD = 8,
   parameter int NUM_WORDS_IN_HDR  = 7,
   parameter int FLUSH_TIMEOUT     = 1024
) (
   input logic          clk,
   input logic          reset,
   evt_pkt_mux_if.slave bus
);
   localparam int DEPTH = 2 ** PLD_DEPTH_BITS;
   localparam int CW    = (NUM_CHAN > 1) ? $clog2(NUM_CHAN) : 1;
   localparam int AGE_W = (FLUSH_TIMEOUT > 0) ? $clog2(FLUSH_TIMEOUT + 1) : 1;
   localparam int PTW   = CTRL_WIDTH + DATA_WIDTH;
   localparam logic [PLD_DEPTH_BITS:0] OCC_FULL = (PLD_DEPTH_BITS+1)'(DEPTH);
   localparam logic [PLD_DEPTH_BITS:0] OCC_PLD  = (PLD_DEPTH_BITS+1)'(NUM_WORDS_PAYLOAD);
   localparam logic [AGE_W-1:0]        AGE_MAX  = AGE_W'(FLUSH_TIMEOUT);
   localparam logic [3:0]              HDR_LAST = 4'(NUM_WORDS_IN_HDR - 1);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_PASS = 2'd1;
   localparam logic [1:0] S_HDR  = 2'd2;
   localparam logic [1:0] S_PLD  = 2'd3;

   logic [1:0]              state_q, state_d;
   logic [CW-1:0]           chan_q, chan_d, last_q, last_d;
   logic [PLD_DEPTH_BITS:0] len_q, len_d, widx_q, widx_d;
   logic [3:0]              hidx_q, hidx_d;
   logic [31:0]             evt_cnt_q;

   logic [WORD_WIDTH-1:0]     pld_mem_q [NUM_CHAN][DEPTH];
   logic [PLD_DEPTH_BITS:0]   occ_q [NUM_CHAN];
   logic [PLD_DEPTH_BITS-1:0] wp_q  [NUM_CHAN];
   logic [PLD_DEPTH_BITS-1:0] rp_q  [NUM_CHAN];
   logic [AGE_W-1:0]          age_q [NUM_CHAN];
   logic [NUM_CHAN-1:0]       full, elig, pld_we;

   logic [PTW-1:0] pt_mem_q [8];
   logic [2:0]     pt_wp_q, pt_rp_q;
   logic [3:0]     pt_cnt_q;
   logic           pt_full, pt_empty, pt_we, pt_rd;
   logic [PTW-1:0] pt_head;

   logic                    found, start, pld_rd, sent;
   logic [CW-1:0]           pick;
   logic [PLD_DEPTH_BITS:0] pick_len;

   assign pt_full  = pt_cnt_q[3];
   assign pt_empty = (pt_cnt_q == 4'd0);
   assign pt_we    = bus.in_wr && !pt_full;
   assign pt_head  = pt_mem_q[pt_rp_q];

   always_comb begin
      for (int c = 0; c < NUM_CHAN; c++) begin
         full[c]   = (occ_q[c] == OCC_FULL);
         pld_we[c] = bus.pld_wr[c] && !full[c];
         elig[c]   = (occ_q[c] >= OCC_PLD) ||
                     ((FLUSH_TIMEOUT != 0) && (occ_q[c] != '0) && (age_q[c] == AGE_MAX));
      end
   end

   // Round-robin search begins one past the channel served last.
   always_comb begin
      int idx;
      idx   = 0;
      found = 1'b0;
      pick  = last_q;
      for (int i = 1; i <= NUM_CHAN; i++) begin
         idx = (int'(last_q) + i) % NUM_CHAN;
         if (!found && elig[idx]) begin
            found = 1'b1;
            pick  = CW'(idx);
         end
      end
      pick_len = (occ_q[pick] >= OCC_PLD) ? OCC_PLD : occ_q[pick];
   end

   always_comb begin
      state_d      = state_q;
      chan_d       = chan_q;
      last_d       = last_q;
      len_d        = len_q;
      widx_d       = widx_q;
      hidx_d       = hidx_q;
      bus.out_wr   = 1'b0;
      bus.out_data = '0;
      bus.out_ctrl = '0;
      pt_rd        = 1'b0;
      pld_rd       = 1'b0;
      start        = 1'b0;
      sent         = 1'b0;
      case (state_q)
         S_IDLE: if (bus.out_rdy) begin
            if (found) begin
               start        = 1'b1;
               bus.out_wr   = 1'b1;
               bus.out_data = bus.hdr_data;
               bus.out_ctrl = bus.hdr_ctrl;
               chan_d       = pick;
               last_d       = pick;
               len_d        = pick_len;
               widx_d       = '0;
               if (NUM_WORDS_IN_HDR == 1) begin
                  state_d = S_PLD;
                  hidx_d  = 4'd0;
               end else begin
                  state_d = S_HDR;
                  hidx_d  = 4'd1;
               end
            end else if (!pt_empty) begin
               pt_rd                        = 1'b1;
               bus.out_wr                   = 1'b1;
               {bus.out_ctrl, bus.out_data} = pt_head;
               if (pt_head[PTW-1 -: CTRL_WIDTH] == '0) state_d = S_PASS;
            end
         end
         // Any non-zero ctrl inside a packet marks its final word.
         S_PASS: if (bus.out_rdy && !pt_empty) begin
            pt_rd                        = 1'b1;
            bus.out_wr                   = 1'b1;
            {bus.out_ctrl, bus.out_data} = pt_head;
            if (pt_head[PTW-1 -: CTRL_WIDTH] != '0) state_d = S_IDLE;
         end
         S_HDR: if (bus.out_rdy) begin
            bus.out_wr   = 1'b1;
            bus.out_data = bus.hdr_data;
            bus.out_ctrl = bus.hdr_ctrl;
            if (hidx_q == HDR_LAST) begin
               state_d = S_PLD;
               hidx_d  = 4'd0;
            end else begin
               hidx_d = hidx_q + 4'd1;
            end
         end
         S_PLD: if (bus.out_rdy && (occ_q[chan_q] != '0)) begin
            pld_rd       = 1'b1;
            bus.out_wr   = 1'b1;
            bus.out_data = pld_mem_q[chan_q][rp_q[chan_q]];
            if (widx_q == len_q - 1'b1) begin
               bus.out_ctrl = CTRL_WIDTH'(1);
               sent         = 1'b1;
               state_d      = S_IDLE;
               widx_d       = '0;
            end else begin
               widx_d = widx_q + 1'b1;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q   <= S_IDLE;
         chan_q    <= '0;
         last_q    <= '0;
         len_q     <= '0;
         widx_q    <= '0;
         hidx_q    <= '0;
         evt_cnt_q <= '0;
         pt_wp_q   <= '0;
         pt_rp_q   <= '0;
         pt_cnt_q  <= '0;
      end else begin
         state_q <= state_d;
         chan_q  <= chan_d;
         last_q  <= last_d;
         len_q   <= len_d;
         widx_q  <= widx_d;
         hidx_q  <= hidx_d;
         if (sent)  evt_cnt_q <= evt_cnt_q + 32'd1;
         if (pt_we) pt_wp_q   <= pt_wp_q + 3'd1;
         if (pt_rd) pt_rp_q   <= pt_rp_q + 3'd1;
         case ({pt_we, pt_rd})
            2'b10:   pt_cnt_q <= pt_cnt_q + 4'd1;
            2'b01:   pt_cnt_q <= pt_cnt_q - 4'd1;
            default: pt_cnt_q <= pt_cnt_q;
         endcase
      end
   end

   // Age only advances while the output is accepting, so a stall cannot trigger a flush.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int c = 0; c < NUM_CHAN; c++) begin
            occ_q[c] <= '0;
            wp_q[c]  <= '0;
            rp_q[c]  <= '0;
            age_q[c] <= '0;
         end
      end else begin
         for (int c = 0; c < NUM_CHAN; c++) begin
            logic rd;
            rd = pld_rd && (chan_q == CW'(c));
            if (pld_we[c]) wp_q[c] <= wp_q[c] + 1'b1;
            if (rd)        rp_q[c] <= rp_q[c] + 1'b1;
            if (pld_we[c] && !rd)      occ_q[c] <= occ_q[c] + 1'b1;
            else if (!pld_we[c] && rd) occ_q[c] <= occ_q[c] - 1'b1;
            if ((occ_q[c] == '0) || (start && (pick == CW'(c)))) age_q[c] <= '0;
            else if (bus.out_rdy && (age_q[c] != AGE_MAX))      age_q[c] <= age_q[c] + 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (pt_we) pt_mem_q[pt_wp_q] <= {bus.in_ctrl, bus.in_data};
      for (int c = 0; c < NUM_CHAN; c++)
         if (pld_we[c]) pld_mem_q[c][wp_q[c]] <= bus.pld_din[c*WORD_WIDTH +: WORD_WIDTH];
   end

   assign bus.in_rdy        = !pt_full;
   assign bus.pld_full      = full;
   assign bus.hdr_word_num  = hidx_q;
   assign bus.evt_chan      = 3'((state_q == S_IDLE && found) ? pick : chan_q);
   assign bus.evt_len       = (state_q == S_IDLE && found) ? pick_len : len_q;
   assign bus.evt_pkt_sent  = sent;
   assign bus.evt_pkt_count = evt_cnt_q;
endmodule
